// File: rtl/pc_lut_pkg.sv
// Shared constants, reset-default branch targets and loader FSM states
// for the programmable PC lookup table.
package pc_lut_pkg;

    localparam int AW   = 4;
    localparam int N    = 1 << AW;
    localparam int DMAX = 16;

    // Entry i is element i; each instance keeps the low D bits.
    localparam logic [0:N-1][DMAX-1:0] PC_LUT_DEFAULT = '{
        16'd0,  16'd11, 16'd80, 16'd68, 16'd113, 16'd53, 16'd56, 16'd59,
        16'd79, 16'd20, 16'd95, 16'd0,  16'd0,   16'd0,  16'd0,  16'd0
    };

    typedef enum logic [2:0] {
        IDLE,
        COUNT,
        LO,
        HI,
        DONE
    } loader_state_t;

endpackage

// File: rtl/pc_lut_loader_if.sv
// Loader byte stream, session status and fetch-stage read port bundled
// for the PC lookup table.
interface pc_lut_loader_if #(
    parameter int D = 10
) ();

    logic                       load_start;
    logic                       in_valid;
    logic [7:0]                 in_data;
    logic                       in_ready;
    logic [pc_lut_pkg::AW-1:0]  addr;
    logic [D-1:0]               target;
    logic                       busy;
    logic                       done;
    logic                       err;

    modport master (
        output load_start, in_valid, in_data, addr,
        input  in_ready, target, busy, done, err
    );

    modport slave (
        input  load_start, in_valid, in_data, addr,
        output in_ready, target, busy, done, err
    );

endinterface

// File: rtl/pc_lut_regfile.sv
// N x D branch-target register array: resets to PC_LUT_DEFAULT, one
// synchronous write port, one combinational read port.
module pc_lut_regfile
    import pc_lut_pkg::*;
#(
    parameter int D = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [D-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [D-1:0]  rdata
);

    logic [D-1:0] mem_q [N];
    logic [D-1:0] mem_d [N];

    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    // NOTE: this array is reset on purpose -- it must come up holding the
    // default jump table; a plain storage RAM would not be reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                mem_q[i] <= PC_LUT_DEFAULT[i][D-1:0];
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/pc_lut_loader.sv
// Byte-stream programmer for the branch-target table: count byte, then
// low/high byte pairs written to consecutive entries from index 0.
module pc_lut_loader
    import pc_lut_pkg::*;
#(
    parameter int D = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    pc_lut_loader_if.slave   bus
);

    localparam int CW = AW + 1;

    loader_state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] count_q, count_d;
    logic [7:0]    stage_q, stage_d;
    logic          err_q, err_d;

    logic          xfer;
    logic          we;
    logic [D-1:0]  wdata;
    logic [7:0]    ovf_bits;

    assign xfer     = bus.in_valid && bus.in_ready;
    assign wdata    = D'({bus.in_data, stage_q});
    // High-byte bits that do not fit in a D-bit target.
    assign ovf_bits = bus.in_data >> (D - 8);

    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        count_d = count_q;
        stage_d = stage_q;
        err_d   = err_q;
        we      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.load_start) begin
                    state_d = COUNT;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                end
            end
            COUNT: begin
                if (xfer) begin
                    if (bus.in_data == 8'd0) begin
                        state_d = DONE;
                    end else if (bus.in_data > 8'(N)) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        count_d = CW'(bus.in_data);
                        state_d = LO;
                    end
                end
            end
            LO: begin
                if (xfer) begin
                    stage_d = bus.in_data;
                    state_d = HI;
                end
            end
            HI: begin
                if (xfer) begin
                    we    = 1'b1;
                    cnt_d = cnt_q + CW'(1);
                    if (ovf_bits != 8'd0) begin
                        err_d = 1'b1;
                    end
                    state_d = (cnt_q + CW'(1) == count_q) ? DONE : LO;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers take non-blocking assignments only; the
    // blocking ones above stay inside the combinational process.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            count_q <= '0;
            stage_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            count_q <= count_d;
            stage_q <= stage_d;
            err_q   <= err_d;
        end
    end

    assign bus.in_ready = (state_q == COUNT) || (state_q == LO) || (state_q == HI);
    assign bus.busy     = bus.in_ready;
    assign bus.done     = (state_q == DONE);
    assign bus.err      = err_q;

    pc_lut_regfile #(.D(D)) u_regfile (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (we),
        .waddr (cnt_q[AW-1:0]),
        .wdata (wdata),
        .raddr (bus.addr),
        .rdata (bus.target)
    );

endmodule

// File: tb/tb_pc_lut_loader.sv
// Directed bench for pc_lut_loader: table reads are queued on a scoreboard
// as sessions are driven and drained against the read port afterwards.
module tb_pc_lut_loader;

    localparam int D = 10;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    pc_lut_loader_if #(.D(D)) bus ();

    pc_lut_loader #(.D(D)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [3:0]  a;
        logic [15:0] v;
        string       tag;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] model [16];
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_defaults();
        model = '{16'd0, 16'd11, 16'd80, 16'd68, 16'd113, 16'd53, 16'd56, 16'd59,
                  16'd79, 16'd20, 16'd95, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    endtask

    task automatic push_table(input string tag);
        for (int i = 0; i < 16; i++) begin
            sb.push_back('{a: 4'(i), v: model[i], tag: tag});
        end
    endtask

    // Steps of #2 from an edge+1 start never land on a rising edge.
    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            bus.addr = e.a;
            #2;
            check($sformatf("%s[%0d]", e.tag, e.a), 32'(bus.target), 32'(e.v));
        end
        tick();
    endtask

    task automatic start();
        bus.load_start = 1'b1;
        tick();
        bus.load_start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        int n;
        for (int g = 0; g < gap; g++) begin
            tick();
            check("gap_ready", 32'(bus.in_ready), 32'd1);
            check("gap_done", 32'(bus.done), 32'd0);
        end
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        n = 0;
        while (!bus.in_ready && n < 20) begin
            tick();
            n++;
        end
        if (n == 20) check("ready_timeout", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        #2;
        check("rst_ready", 32'(bus.in_ready), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        tick();
        rst_n = 1'b1;
        model_defaults();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n          = 1'b0;
        bus.load_start = 1'b0;
        bus.in_valid   = 1'b0;
        bus.in_data    = 8'h00;
        bus.addr       = 4'd0;
        tick();
        reset_dut();
        push_table("dflt");
        drain();

        // Two entries, back-to-back bytes.
        start();
        send(8'h02, 0);
        send(8'h2C, 0);
        send(8'h01, 0);
        send(8'hFF, 0);
        check("s1_done_early", 32'(bus.done), 32'd0);
        send(8'h03, 0);
        check("s1_done", 32'(bus.done), 32'd1);
        check("s1_err", 32'(bus.err), 32'd0);
        check("s1_ready", 32'(bus.in_ready), 32'd0);
        tick();
        check("s1_done_off", 32'(bus.done), 32'd0);
        model[0] = 16'd300;
        model[1] = 16'd1023;
        push_table("s1");
        drain();

        // Same session from defaults, three idle cycles before each byte.
        reset_dut();
        start();
        send(8'h02, 3);
        send(8'h2C, 3);
        send(8'h01, 3);
        send(8'hFF, 3);
        send(8'h03, 3);
        check("s2_done", 32'(bus.done), 32'd1);
        tick();
        check("s2_done_off", 32'(bus.done), 32'd0);
        tick();
        check("s2_no_extra_done", 32'(bus.done), 32'd0);
        model[0] = 16'd300;
        model[1] = 16'd1023;
        push_table("s2");
        drain();

        // Empty session, then an oversize count.
        start();
        send(8'h00, 0);
        check("c0_done", 32'(bus.done), 32'd1);
        check("c0_err", 32'(bus.err), 32'd0);
        tick();
        check("c0_done_off", 32'(bus.done), 32'd0);
        start();
        send(8'h11, 0);
        check("c17_err", 32'(bus.err), 32'd1);
        check("c17_idle", 32'(bus.in_ready), 32'd0);
        check("c17_done", 32'(bus.done), 32'd0);
        tick();
        check("c17_done_later", 32'(bus.done), 32'd0);
        check("c17_err_sticky", 32'(bus.err), 32'd1);
        push_table("c17");
        drain();

        // Overflow bits in the high byte: truncated write, err with done.
        start();
        check("ovf_err_cleared", 32'(bus.err), 32'd0);
        send(8'h01, 0);
        send(8'h05, 0);
        send(8'hFC, 0);
        check("ovf_done", 32'(bus.done), 32'd1);
        check("ovf_err", 32'(bus.err), 32'd1);
        tick();
        model[0] = 16'd5;
        push_table("ovf");
        drain();
        start();
        check("err_clear", 32'(bus.err), 32'd0);
        send(8'h00, 0);
        tick();

        // Stream bytes while idle must not be consumed.
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h01;
        tick();
        tick();
        bus.in_valid = 1'b0;
        check("idle_ready", 32'(bus.in_ready), 32'd0);
        push_table("idle");
        drain();

        // load_start in HI ignored; write visible next cycle; reset aborts.
        start();
        send(8'h02, 0);
        send(8'h34, 0);
        bus.load_start = 1'b1;
        tick();
        bus.load_start = 1'b0;
        check("hi_busy", 32'(bus.busy), 32'd1);
        check("hi_err", 32'(bus.err), 32'd0);
        bus.addr     = 4'd0;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h02;
        #2;
        check("same_cycle_old", 32'(bus.target), 32'd5);
        tick();
        bus.in_valid = 1'b0;
        check("next_cycle_new", 32'(bus.target), 32'h234);
        check("lo_busy", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        #2;
        check("abort_t0", 32'(bus.target), 32'd0);
        check("abort_ready", 32'(bus.in_ready), 32'd0);
        tick();
        rst_n = 1'b1;
        model_defaults();
        push_table("abort");
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
